br_redirect_ctrl: RTL and testbench
===================================

Name: br_redirect_ctrl

Overview:
- Sequences the front end after the EX-stage branch unit resolves a branch or jump.
- Compares the resolved outcome (taken flag, target) with the fetch-time prediction carried down the pipe and detects mispredicts.
- On a mispredict, issues a redirect to fetch with a valid/ready handshake and flushes the wrong-path IF/ID stages for a bounded drain window.
- Sits between the branch unit, the PC/fetch logic and the pipeline-register flush controls; also keeps a mispredict counter for performance monitoring.

Parameters:
- FLUSH_CYCLES, 2, number of drain cycles that flush_if/flush_id stay asserted after the redirect is accepted (range 1..15).
- CNT_W, 16, width of the mispredict counter.

Ports:
- clk  input  1  system clock, rising edge.
- rstn  input  1  asynchronous active-low reset.
- ex_valid  input  1  EX holds a resolved control-transfer instruction this cycle.
- ex_ifbr  input  1  resolved taken flag from the branch unit.
- ex_brresult  input  32  resolved target from the branch unit.
- ex_pc  input  32  PC of the EX instruction.
- ex_pred_taken  input  1  fetch-time prediction, taken.
- ex_pred_target  input  32  fetch-time predicted target.
- ex_stall  input  1  pipeline stalled; the EX contents are not final this cycle.
- if_ready  input  1  fetch accepts a redirect this cycle.
- redirect_valid  output  1  redirect request to fetch.
- redirect_pc  output  32  correct next PC.
- flush_if  output  1  kill the IF/ID register contents.
- flush_id  output  1  kill the ID/EX register contents.
- busy  output  1  controller not IDLE; EX results are ignored.
- mispredict_cnt  output  CNT_W  saturating count of mispredicts.

Behaviour:
- Reset (asynchronous, rstn=0): state=IDLE.
  - redirect_valid=0, redirect_pc=0.
  - flush_if=0, flush_id=0, busy=0.
  - mispredict_cnt=0, drain counter=0.
- Resolution event: ex_valid & !ex_stall & state==IDLE.
- Mispredict when either holds:
  - ex_ifbr != ex_pred_taken, or
  - ex_ifbr & ex_pred_taken & (ex_brresult != ex_pred_target).
- Correct next PC = ex_ifbr ? ex_brresult : ex_pc+4.
  - The add is a 32-bit modulo add; 0xFFFFFFFC+4 wraps to 0.
- States: IDLE, REDIR, DRAIN.
- IDLE:
  - Mispredict event: at the next edge go to REDIR.
    - redirect_pc is registered.
    - redirect_valid=1, flush_if=1, flush_id=1, busy=1.
    - mispredict_cnt increments.
  - Correct-prediction event or no event: stay in IDLE; all outputs stay 0.
- REDIR:
  - redirect_valid, redirect_pc, flush_if and flush_id are held stable until if_ready=1.
  - On the edge where redirect_valid & if_ready: redirect_valid drops to 0, the drain counter loads FLUSH_CYCLES-1, and the state goes to DRAIN. Flushes stay 1.
  - If if_ready is already 1 in the first REDIR cycle, the handshake completes in one cycle.
- DRAIN:
  - flush_if=flush_id=1 each cycle; the counter decrements.
  - When the counter is 0, at the next edge go to IDLE; flush and busy go low.
  - FLUSH_CYCLES=1 gives exactly one DRAIN cycle.
- Latency:
  - Mispredict detected in cycle N gives redirect_valid=1 in cycle N+1.
  - The minimum IDLE-to-IDLE sequence is 1 REDIR + FLUSH_CYCLES DRAIN cycles.
- While busy=1, ex_valid is ignored. It is wrong-path and is being flushed, so it produces no redirect and no count.
- ex_stall=1 in IDLE:
  - No event.
  - The comparison is re-evaluated in the first non-stalled cycle, so a stalled branch is counted exactly once.
- ex_stall has no effect in REDIR or DRAIN. Flushes override stall in the pipeline registers.
- mispredict_cnt saturates at all ones and never wraps.
- Reset asserted mid-sequence returns the block to IDLE immediately, with all outputs 0 and no redirect completed.
- Outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Reset values: hold rstn=0 for 3 cycles, then release. Required: every output 0 and state IDLE; mispredict_cnt=0.
- Correct prediction: ex_valid=1, ex_ifbr=1, ex_pred_taken=1, ex_brresult=ex_pred_target=0x00001040. Required: redirect_valid stays 0, no flush, cnt stays 0.
- Taken mispredict with one-cycle handshake: ex_pc=0x1000, ex_ifbr=1, ex_brresult=0x2000, ex_pred_taken=0, if_ready=1, FLUSH_CYCLES=2. Required:
  - Cycle N+1: redirect_valid=1 with redirect_pc=0x2000.
  - Cycle N+2: redirect_valid=0.
  - Flushes high for cycles N+1..N+3; busy low at N+4; cnt=1.
- Not-taken mispredict with backpressure: ex_pc=0x1000, ex_ifbr=0, ex_pred_taken=1, if_ready=0 for 4 cycles, then 1. Required:
  - redirect_pc=0x1004, held stable with redirect_valid=1 for 5 cycles.
  - ex_valid pulses during busy cause no further count.
- Target mismatch plus wrap: ex_pred_taken=ex_ifbr=1, ex_pred_target=0x3000, ex_brresult=0x3004. Required: redirect_pc=0x3004 and cnt increments.
  - Separately, ex_ifbr=0, ex_pred_taken=1, ex_pc=0xFFFFFFFC. Required: redirect_pc=0x00000000.
- Reset in REDIR and counter saturation:
  - Pull rstn low while redirect_valid=1 and if_ready=0. Required: outputs 0 asynchronously, before the next clock edge.
  - With CNT_W=4, drive 17 mispredicts. Required: mispredict_cnt=0xF.

Source files
------------

// File: rtl/br_redirect_ctrl.sv
// Branch-resolution redirect controller: detects EX-stage mispredicts, issues a
// valid/ready redirect to fetch, drains the wrong-path IF/ID stages and counts mispredicts.
module br_redirect_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             ex_valid,
  input  logic             ex_ifbr,
  input  logic [31:0]      ex_brresult,
  input  logic [31:0]      ex_pc,
  input  logic             ex_pred_taken,
  input  logic [31:0]      ex_pred_target,
  input  logic             ex_stall,
  input  logic             if_ready,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic             flush_if,
  output logic             flush_id,
  output logic             busy,
  output logic [CNT_W-1:0] mispredict_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REDIR = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [3:0] DRAIN_LOAD = 4'(FLUSH_CYCLES - 1);

  state_t      state;
  logic [3:0]  drain_cnt;
  logic        resolve;
  logic        mispredict;
  logic [31:0] next_pc;

  // A stalled EX instruction is not final; it is evaluated once, when the stall lifts.
  always_comb begin
    resolve    = ex_valid & ~ex_stall & (state == IDLE);
    mispredict = (ex_ifbr != ex_pred_taken) |
                 (ex_ifbr & ex_pred_taken & (ex_brresult != ex_pred_target));
    next_pc    = ex_ifbr ? ex_brresult : (ex_pc + 32'd4);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state          <= IDLE;
      drain_cnt      <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      flush_if       <= 1'b0;
      flush_id       <= 1'b0;
      busy           <= 1'b0;
      mispredict_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (resolve && mispredict) begin
            state          <= REDIR;
            redirect_valid <= 1'b1;
            redirect_pc    <= next_pc;
            flush_if       <= 1'b1;
            flush_id       <= 1'b1;
            busy           <= 1'b1;
            if (mispredict_cnt != '1) begin
              mispredict_cnt <= mispredict_cnt + CNT_W'(1);
            end
          end
        end
        REDIR: begin
          if (if_ready) begin
            redirect_valid <= 1'b0;
            drain_cnt      <= DRAIN_LOAD;
            state          <= DRAIN;
          end
        end
        DRAIN: begin
          if (drain_cnt == '0) begin
            state    <= IDLE;
            flush_if <= 1'b0;
            flush_id <= 1'b0;
            busy     <= 1'b0;
          end else begin
            drain_cnt <= drain_cnt - 4'd1;
          end
        end
        default: begin
          state          <= IDLE;
          redirect_valid <= 1'b0;
          flush_if       <= 1'b0;
          flush_id       <= 1'b0;
          busy           <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_br_redirect_ctrl.sv
// Scoreboard bench for br_redirect_ctrl: two instances (FLUSH_CYCLES=2/CNT_W=16 and
// FLUSH_CYCLES=1/CNT_W=4) share stimulus and are checked against a cycle-index model.
module tb_br_redirect_ctrl;

  localparam int FC0 = 2;
  localparam int FC1 = 1;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        ex_valid, ex_ifbr, ex_pred_taken, ex_stall, if_ready;
  logic [31:0] ex_brresult, ex_pc, ex_pred_target;
  logic        rv [2];
  logic        fi [2];
  logic        fd [2];
  logic        bz [2];
  logic [31:0] rp [2];
  logic [15:0] cnt0;
  logic [3:0]  cnt1;

  always #5 clk = ~clk;

  br_redirect_ctrl #(.FLUSH_CYCLES(FC0), .CNT_W(16)) dut (
    .clk(clk), .rstn(rstn), .ex_valid(ex_valid), .ex_ifbr(ex_ifbr),
    .ex_brresult(ex_brresult), .ex_pc(ex_pc), .ex_pred_taken(ex_pred_taken),
    .ex_pred_target(ex_pred_target), .ex_stall(ex_stall), .if_ready(if_ready),
    .redirect_valid(rv[0]), .redirect_pc(rp[0]), .flush_if(fi[0]), .flush_id(fd[0]),
    .busy(bz[0]), .mispredict_cnt(cnt0)
  );

  br_redirect_ctrl #(.FLUSH_CYCLES(FC1), .CNT_W(4)) dut_sat (
    .clk(clk), .rstn(rstn), .ex_valid(ex_valid), .ex_ifbr(ex_ifbr),
    .ex_brresult(ex_brresult), .ex_pc(ex_pc), .ex_pred_taken(ex_pred_taken),
    .ex_pred_target(ex_pred_target), .ex_stall(ex_stall), .if_ready(if_ready),
    .redirect_valid(rv[1]), .redirect_pc(rp[1]), .flush_if(fi[1]), .flush_id(fd[1]),
    .busy(bz[1]), .mispredict_cnt(cnt1)
  );

  typedef struct {
    logic [31:0] pc;
    longint      cnt;
  } exp_t;

  exp_t   sb0[$];
  exp_t   sb1[$];
  int     tests = 0;
  int     fails = 0;
  bit     done = 1'b0;
  bit     sat_req = 1'b0;

  // Reference model: a redirect is owed from the cycle after a mispredict until the first
  // cycle fetch is ready (cycle index acc); busy lasts until cycle acc+FLUSH_CYCLES.
  longint cyc = 0;
  bit     m_active [2];
  longint m_acc [2];
  longint m_cnt [2];

  function automatic longint fc_of(input int i);
    return (i == 0) ? FC0 : FC1;
  endfunction

  function automatic longint cmax_of(input int i);
    return (i == 0) ? 65535 : 15;
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 2; i++) begin
        m_active[i] = 1'b0;
        m_acc[i]    = -1;
        m_cnt[i]    = 0;
      end
      sb0.delete();
      sb1.delete();
    end else begin
      bit   mis;
      exp_t e;
      cyc++;
      mis = (ex_ifbr != ex_pred_taken) ||
            (ex_ifbr && ex_pred_taken && (ex_brresult != ex_pred_target));
      for (int i = 0; i < 2; i++) begin
        if (m_active[i]) begin
          if (m_acc[i] < 0) begin
            if (if_ready) m_acc[i] = cyc;
          end else if (cyc == m_acc[i] + fc_of(i)) begin
            m_active[i] = 1'b0;
          end
        end else if (ex_valid && !ex_stall && mis) begin
          m_active[i] = 1'b1;
          m_acc[i]    = -1;
          if (m_cnt[i] < cmax_of(i)) m_cnt[i]++;
          e.pc  = ex_ifbr ? ex_brresult : (ex_pc + 32'd4);
          e.cnt = m_cnt[i];
          if (i == 0) sb0.push_back(e);
          else        sb1.push_back(e);
        end
      end
    end
  end

  task automatic chk(input string name, input int i, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s dut%0d: got 0x%0h expected 0x%0h at %0t", name, i, act, exp, $time);
    end
  endtask

  // Monitor: per-cycle output checks plus scoreboard pops on each new redirect.
  initial begin
    bit          prev [2];
    logic [31:0] held [2];
    bit          rst_seen;
    bit          ok;
    longint      cv;
    exp_t        e;
    prev     = '{1'b0, 1'b0};
    held     = '{32'h0, 32'h0};
    rst_seen = 1'b1;
    forever begin
      @(negedge clk or negedge rstn);
      if (!rstn && !rst_seen) begin
        rst_seen = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
          cv = (i == 0) ? longint'(cnt0) : longint'(cnt1);
          chk("async_rst_valid", i, longint'(rv[i]), 0);
          chk("async_rst_pc",    i, longint'(rp[i]), 0);
          chk("async_rst_flush", i, longint'({fi[i], fd[i]}), 0);
          chk("async_rst_busy",  i, longint'(bz[i]), 0);
          chk("async_rst_cnt",   i, cv, 0);
        end
        prev = '{1'b0, 1'b0};
        continue;
      end
      if (rstn) rst_seen = 1'b0;
      for (int i = 0; i < 2; i++) begin
        cv = (i == 0) ? longint'(cnt0) : longint'(cnt1);
        chk("redirect_valid", i, longint'(rv[i]), longint'(m_active[i] && m_acc[i] < 0));
        chk("flush_if",       i, longint'(fi[i]), longint'(m_active[i]));
        chk("flush_id",       i, longint'(fd[i]), longint'(m_active[i]));
        chk("busy",           i, longint'(bz[i]), longint'(m_active[i]));
        chk("mispredict_cnt", i, cv, m_cnt[i]);
        if (rv[i] === 1'b1 && !prev[i]) begin
          ok = (i == 0) ? (sb0.size() > 0) : (sb1.size() > 0);
          chk("redirect_expected", i, longint'(ok), 1);
          if (ok) begin
            if (i == 0) e = sb0.pop_front();
            else        e = sb1.pop_front();
            chk("redirect_pc",  i, longint'(rp[i]), longint'(e.pc));
            chk("redirect_cnt", i, cv, e.cnt);
            held[i] = e.pc;
          end
        end else if (rv[i] === 1'b1) begin
          chk("redirect_pc_hold", i, longint'(rp[i]), longint'(held[i]));
        end
        prev[i] = (rv[i] === 1'b1);
      end
      if (sat_req) chk("cnt_saturated", 1, longint'(cnt1), 15);
      if (done) begin
        chk("scoreboard_empty", 0, longint'(sb0.size()), 0);
        chk("scoreboard_empty", 1, longint'(sb1.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
      end
    end
  end

  task automatic drive(input logic v, input logic ifbr, input logic [31:0] br,
                       input logic [31:0] pc, input logic pt, input logic [31:0] ptg,
                       input logic st, input logic rdy);
    ex_valid       = v;
    ex_ifbr        = ifbr;
    ex_brresult    = br;
    ex_pc          = pc;
    ex_pred_taken  = pt;
    ex_pred_target = ptg;
    ex_stall       = st;
    if_ready       = rdy;
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int k = 0; k < n; k++) drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, rdy);
  endtask

  // Stimulus
  initial begin
    logic [31:0] t, pcv, ptg;
    ex_valid = 1'b0; ex_ifbr = 1'b0; ex_brresult = '0; ex_pc = '0;
    ex_pred_taken = 1'b0; ex_pred_target = '0; ex_stall = 1'b0; if_ready = 1'b0;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    idle(2, 1'b1);

    // correct prediction: no redirect
    drive(1'b1, 1'b1, 32'h1040, 32'h1000, 1'b1, 32'h1040, 1'b0, 1'b1);
    idle(3, 1'b1);
    // taken mispredict, fetch ready immediately
    drive(1'b1, 1'b1, 32'h2000, 32'h1000, 1'b0, 32'h0, 1'b0, 1'b1);
    idle(5, 1'b1);
    // not-taken mispredict with 4 cycles of backpressure and wrong-path ex_valid pulses
    drive(1'b1, 1'b0, 32'h0, 32'h1000, 1'b1, 32'h5000, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++)
      drive(1'(k % 2), 1'b1, 32'h7000, 32'h1100, 1'b0, 32'h0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 32'h7000, 32'h1100, 1'b0, 32'h0, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 32'h0, 32'h1200, 1'b1, 32'h0, 1'b0, 1'b1);
    idle(4, 1'b1);
    // taken with target mismatch
    drive(1'b1, 1'b1, 32'h3004, 32'h2FF0, 1'b1, 32'h3000, 1'b0, 1'b1);
    idle(4, 1'b1);
    // fall-through wraps to zero
    drive(1'b1, 1'b0, 32'h0, 32'hFFFF_FFFC, 1'b1, 32'h100, 1'b0, 1'b1);
    idle(4, 1'b1);
    // stalled mispredict is counted once, when the stall lifts
    repeat (3) drive(1'b1, 1'b1, 32'h4000, 32'h3F00, 1'b0, 32'h0, 1'b1, 1'b1);
    drive(1'b1, 1'b1, 32'h4000, 32'h3F00, 1'b0, 32'h0, 1'b0, 1'b1);
    idle(4, 1'b1);

    // asynchronous reset while a redirect is pending
    drive(1'b1, 1'b1, 32'h6000, 32'h5000, 1'b0, 32'h0, 1'b0, 1'b0);
    idle(1, 1'b0);
    #2 rstn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    idle(2, 1'b1);

    // 17 mispredicts saturate the 4-bit counter
    for (int k = 0; k < 17; k++) begin
      drive(1'b1, 1'b0, 32'h0, 32'h100 + 32'(k) * 4, 1'b1, 32'h0, 1'b0, 1'b1);
      idle(4, 1'b1);
    end
    #2 sat_req = 1'b1;
    @(negedge clk);
    #2 sat_req = 1'b0;

    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      t   = ($urandom_range(0, 3) == 0) ? $urandom : (32'h3000 + 32'($urandom_range(0, 1)) * 4);
      pcv = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
      ptg = ($urandom_range(0, 1) == 0) ? t : (t ^ 32'h4);
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), t, pcv,
            1'($urandom_range(0, 1)), ptg, 1'($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 4) < 3));
    end
    idle(8, 1'b1);
    #2 done = 1'b1;
  end

endmodule
